// File: rtl/pfreq_buf.sv
// Prefetch request buffer: in-order FIFO from the prefetch engine to the data
// cache with line-granular duplicate suppression and L2-to-DC upgrade.
module pfreq_buf #(
    parameter int unsigned LADDR_W   = 39,
    parameter int unsigned SPTBR_W   = 38,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned LINE_BITS = 6,
    parameter int unsigned STAT_W    = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   pftodc_req_valid,
    output logic                   pftodc_req_retry,
    input  logic [LADDR_W-1:0]     pftodc_req_laddr,
    input  logic [SPTBR_W-1:0]     pftodc_req_sptbr,
    input  logic                   pftodc_req_l2,
    output logic                   dcreq_valid,
    input  logic                   dcreq_retry,
    output logic [LADDR_W-1:0]     dcreq_laddr,
    output logic [SPTBR_W-1:0]     dcreq_sptbr,
    output logic                   dcreq_l2,
    output logic [STAT_W-1:0]      stats_nreqs,
    output logic [STAT_W-1:0]      stats_ndrop,
    output logic [$clog2(DEPTH):0] occupancy
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    logic [LADDR_W-1:0] laddr_mem [DEPTH];
    logic [SPTBR_W-1:0] sptbr_mem [DEPTH];
    logic [DEPTH-1:0]   l2_mem;

    logic [LADDR_W-1:0] laddr_n [DEPTH];
    logic [SPTBR_W-1:0] sptbr_n [DEPTH];
    logic [DEPTH-1:0]   l2_n;

    logic [PTR_W-1:0] head_q, tail_q, head_n, tail_n;
    logic [OCC_W-1:0] occ_n;
    logic [DEPTH-1:0] hit;
    logic             dup, push_acc, pop, wr;

    // Next-state of the entry array, pointers and occupancy from cycle-start state.
    always_comb begin
        hit      = '0;
        push_acc = pftodc_req_valid && !pftodc_req_retry;
        pop      = dcreq_valid && !dcreq_retry;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            hit[i] = ({1'b0, PTR_W'(PTR_W'(i) - head_q)} < occupancy)
                  && (sptbr_mem[i] == pftodc_req_sptbr)
                  && (laddr_mem[i][LADDR_W-1:LINE_BITS] == pftodc_req_laddr[LADDR_W-1:LINE_BITS]);
        end
        dup     = |hit;
        wr      = push_acc && !dup;
        laddr_n = laddr_mem;
        sptbr_n = sptbr_mem;
        l2_n    = l2_mem;
        // A DC-fill duplicate promotes the matching L2-only entry in place.
        if (push_acc && dup && !pftodc_req_l2) begin
            l2_n = l2_mem & ~hit;
        end
        if (wr) begin
            laddr_n[tail_q] = pftodc_req_laddr;
            sptbr_n[tail_q] = pftodc_req_sptbr;
            l2_n[tail_q]    = pftodc_req_l2;
        end
        head_n = head_q + PTR_W'(pop);
        tail_n = tail_q + PTR_W'(wr);
        occ_n  = occupancy + OCC_W'(wr) - OCC_W'(pop);
    end

    // Entry storage carries no reset; validity is tracked by occupancy.
    always_ff @(posedge clk) begin
        laddr_mem <= laddr_n;
        sptbr_mem <= sptbr_n;
        l2_mem    <= l2_n;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q           <= '0;
            tail_q           <= '0;
            occupancy        <= '0;
            dcreq_valid      <= 1'b0;
            pftodc_req_retry <= 1'b0;
            dcreq_laddr      <= '0;
            dcreq_sptbr      <= '0;
            dcreq_l2         <= 1'b0;
            stats_nreqs      <= '0;
            stats_ndrop      <= '0;
        end else begin
            head_q           <= head_n;
            tail_q           <= tail_n;
            occupancy        <= occ_n;
            dcreq_valid      <= (occ_n != '0);
            pftodc_req_retry <= (occ_n == OCC_W'(DEPTH));
            dcreq_laddr      <= laddr_n[head_n];
            dcreq_sptbr      <= sptbr_n[head_n];
            dcreq_l2         <= l2_n[head_n];
            if (wr && (stats_nreqs != '1)) begin
                stats_nreqs <= stats_nreqs + STAT_W'(1);
            end
            if (push_acc && dup && (stats_ndrop != '1)) begin
                stats_ndrop <= stats_ndrop + STAT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pfreq_buf.sv
// Self-checking bench for pfreq_buf: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_pfreq_buf;

    localparam int LW   = 39;
    localparam int SW   = 38;
    localparam int DEP  = 4;
    localparam int LB   = 6;
    localparam int STW  = 8;
    localparam int MAXS = (1 << STW) - 1;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            pftodc_req_valid = 1'b0;
    logic            pftodc_req_retry;
    logic [LW-1:0]   pftodc_req_laddr = '0;
    logic [SW-1:0]   pftodc_req_sptbr = '0;
    logic            pftodc_req_l2 = 1'b0;
    logic            dcreq_valid;
    logic            dcreq_retry = 1'b1;
    logic [LW-1:0]   dcreq_laddr;
    logic [SW-1:0]   dcreq_sptbr;
    logic            dcreq_l2;
    logic [STW-1:0]  stats_nreqs;
    logic [STW-1:0]  stats_ndrop;
    logic [$clog2(DEP):0] occupancy;

    pfreq_buf #(
        .LADDR_W(LW), .SPTBR_W(SW), .DEPTH(DEP), .LINE_BITS(LB), .STAT_W(STW)
    ) dut (
        .clk(clk), .reset(reset),
        .pftodc_req_valid(pftodc_req_valid), .pftodc_req_retry(pftodc_req_retry),
        .pftodc_req_laddr(pftodc_req_laddr), .pftodc_req_sptbr(pftodc_req_sptbr),
        .pftodc_req_l2(pftodc_req_l2),
        .dcreq_valid(dcreq_valid), .dcreq_retry(dcreq_retry),
        .dcreq_laddr(dcreq_laddr), .dcreq_sptbr(dcreq_sptbr), .dcreq_l2(dcreq_l2),
        .stats_nreqs(stats_nreqs), .stats_ndrop(stats_ndrop), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [LW-1:0] laddr;
        logic [SW-1:0] sptbr;
        logic          l2;
    } ent_t;

    ent_t q[$];
    int   m_nreqs = 0;
    int   m_ndrop = 0;
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One cycle of the reference behaviour, evaluated on the cycle-start queue.
    task automatic model_cycle();
        bit   acc, pop, dup;
        ent_t e;
        acc = pftodc_req_valid && (q.size() != DEP);
        pop = (q.size() != 0) && !dcreq_retry;
        dup = 1'b0;
        if (acc) begin
            foreach (q[i]) begin
                if (q[i].sptbr == pftodc_req_sptbr &&
                    (q[i].laddr >> LB) == (pftodc_req_laddr >> LB)) begin
                    dup = 1'b1;
                    if (!pftodc_req_l2) begin
                        e = q[i];
                        e.l2 = 1'b0;
                        q[i] = e;
                    end
                end
            end
        end
        if (pop) void'(q.pop_front());
        if (acc) begin
            if (dup) begin
                if (m_ndrop < MAXS) m_ndrop++;
            end else begin
                if (m_nreqs < MAXS) m_nreqs++;
                e.laddr = pftodc_req_laddr;
                e.sptbr = pftodc_req_sptbr;
                e.l2    = pftodc_req_l2;
                q.push_back(e);
            end
        end
    endtask

    task automatic check_all();
        chk("occupancy", 64'(occupancy), 64'(q.size()));
        chk("dcreq_valid", 64'(dcreq_valid), 64'(q.size() != 0));
        chk("req_retry", 64'(pftodc_req_retry), 64'(q.size() == DEP));
        chk("stats_nreqs", 64'(stats_nreqs), 64'(m_nreqs));
        chk("stats_ndrop", 64'(stats_ndrop), 64'(m_ndrop));
        if (q.size() != 0) begin
            chk("dcreq_laddr", 64'(dcreq_laddr), 64'(q[0].laddr));
            chk("dcreq_sptbr", 64'(dcreq_sptbr), 64'(q[0].sptbr));
            chk("dcreq_l2", 64'(dcreq_l2), 64'(q[0].l2));
        end
    endtask

    task automatic step(input logic v, input logic [LW-1:0] a, input logic [SW-1:0] s,
                        input logic l2, input logic dr);
        pftodc_req_valid = v;
        pftodc_req_laddr = a;
        pftodc_req_sptbr = s;
        pftodc_req_l2    = l2;
        dcreq_retry      = dr;
        model_cycle();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic drain();
        for (int k = 0; k < DEP + 2 && q.size() != 0; k++) step(1'b0, '0, '0, 1'b0, 1'b0);
        chk("drained", 64'(occupancy), 64'(0));
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_occ"}, 64'(occupancy), 64'(0));
        chk({tag, "_valid"}, 64'(dcreq_valid), 64'(0));
        chk({tag, "_retry"}, 64'(pftodc_req_retry), 64'(0));
        chk({tag, "_nreqs"}, 64'(stats_nreqs), 64'(0));
        chk({tag, "_ndrop"}, 64'(stats_ndrop), 64'(0));
    endtask

    initial begin
        logic [LW-1:0] order [4];
        int d0;

        // Power-on reset, released away from a clock edge.
        #1 reset = 1'b0;
        #2 check_reset_state("por");
        #9 reset = 1'b1;

        // Fill with four distinct lines while the DC refuses; fifth is held off.
        step(1'b1, LW'('h1000), SW'(1), 1'b0, 1'b1);
        chk("first_accept_occ", 64'(occupancy), 64'(1));
        step(1'b1, LW'('h2000), SW'(1), 1'b0, 1'b1);
        step(1'b1, LW'('h3000), SW'(1), 1'b0, 1'b1);
        step(1'b1, LW'('h4000), SW'(1), 1'b0, 1'b1);
        chk("full_occ", 64'(occupancy), 64'(4));
        chk("full_retry", 64'(pftodc_req_retry), 64'(1));
        step(1'b1, LW'('h5000), SW'(1), 1'b0, 1'b1);
        chk("fifth_not_taken", 64'(stats_nreqs), 64'(4));
        chk("fifth_occ", 64'(occupancy), 64'(4));

        // One pop frees a slot; refill at the tail and check delivery order.
        step(1'b0, '0, '0, 1'b0, 1'b0);
        chk("after_pop_retry", 64'(pftodc_req_retry), 64'(0));
        step(1'b1, LW'('h5000), SW'(1), 1'b0, 1'b1);
        order[0] = LW'('h2000);
        order[1] = LW'('h3000);
        order[2] = LW'('h4000);
        order[3] = LW'('h5000);
        for (int k = 0; k < 4; k++) begin
            chk("order", 64'(dcreq_laddr), 64'(order[k]));
            step(1'b0, '0, '0, 1'b0, 1'b0);
        end
        chk("order_empty", 64'(dcreq_valid), 64'(0));

        // Same line in same space is dropped; different space is not.
        step(1'b1, LW'('h1000), SW'(1), 1'b0, 1'b1);
        d0 = m_ndrop;
        step(1'b1, LW'('h1020), SW'(1), 1'b0, 1'b1);
        chk("dup_occ", 64'(occupancy), 64'(1));
        chk("dup_ndrop", 64'(stats_ndrop), 64'(d0 + 1));
        step(1'b1, LW'('h1040), SW'(2), 1'b0, 1'b1);
        chk("diff_space_occ", 64'(occupancy), 64'(2));
        drain();

        // L2-only head upgraded by a DC-fill duplicate while held.
        step(1'b1, LW'('h1000), SW'(1), 1'b1, 1'b1);
        chk("l2_head", 64'(dcreq_l2), 64'(1));
        d0 = m_ndrop;
        step(1'b1, LW'('h1008), SW'(1), 1'b0, 1'b1);
        chk("upgrade_l2", 64'(dcreq_l2), 64'(0));
        chk("upgrade_laddr", 64'(dcreq_laddr), 64'('h1000));
        chk("upgrade_ndrop", 64'(stats_ndrop), 64'(d0 + 1));
        drain();

        // Random traffic over a small address pool to provoke duplicates.
        for (int n = 0; n < 400; n++) begin
            step(1'b1 && ($urandom_range(0, 9) < 7),
                 LW'(($urandom_range(0, 5) << 12) | $urandom_range(0, 127)),
                 SW'($urandom_range(1, 2)),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
        end
        drain();

        // Asynchronous reset mid-operation with three entries buffered.
        step(1'b1, LW'('h1000), SW'(5), 1'b0, 1'b1);
        step(1'b1, LW'('h2000), SW'(5), 1'b0, 1'b1);
        step(1'b1, LW'('h3000), SW'(5), 1'b0, 1'b1);
        chk("pre_reset_occ", 64'(occupancy), 64'(3));
        #2 reset = 1'b0;
        #1 check_reset_state("async_rst");
        q.delete();
        m_nreqs = 0;
        m_ndrop = 0;
        pftodc_req_valid = 1'b1;
        pftodc_req_laddr = LW'('h6000);
        dcreq_retry = 1'b0;
        @(posedge clk);
        #1 check_reset_state("held_rst");
        #3 reset = 1'b1;
        step(1'b1, LW'('h6000), SW'(5), 1'b0, 1'b1);
        chk("resume_occ", 64'(occupancy), 64'(1));

        // Duplicate counter saturates rather than wrapping.
        for (int n = 0; n < (1 << STW) + 5; n++) begin
            step(1'b1, LW'('h6010), SW'(5), 1'b0, 1'b1);
        end
        chk("ndrop_saturated", 64'(stats_ndrop), 64'(MAXS));
        chk("sat_occ", 64'(occupancy), 64'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pfreq_buf.md
PFREQ_BUF -- requirements
Module: pfreq_buf

Interface
REQ-001 SHALL have parameter LADDR_W, default 39: request line-address width.
REQ-002 SHALL have parameter SPTBR_W, default 38: page-table base width.
REQ-003 SHALL have parameter DEPTH, default 4, power of two >= 2: buffer entries.
REQ-004 SHALL have parameter LINE_BITS, default 6: low laddr bits ignored for duplicate compare.
REQ-005 SHALL have parameter STAT_W, default 16: statistic counter width.
REQ-006 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-007 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-008 SHALL have port pftodc_req_valid, input, 1: request offered by prefetch engine.
REQ-009 SHALL have port pftodc_req_retry, output, 1: buffer cannot accept this cycle.
REQ-010 SHALL have port pftodc_req_laddr, input, LADDR_W: request address.
REQ-011 SHALL have port pftodc_req_sptbr, input, SPTBR_W: request address space.
REQ-012 SHALL have port pftodc_req_l2, input, 1: request targets L2 only.
REQ-013 SHALL have port dcreq_valid, output, 1: head entry presented to DC.
REQ-014 SHALL have port dcreq_retry, input, 1: DC refuses head this cycle.
REQ-015 SHALL have ports dcreq_laddr, dcreq_sptbr, dcreq_l2, outputs, LADDR_W/SPTBR_W/1: head entry fields.
REQ-016 SHALL have port stats_nreqs, output, STAT_W: requests enqueued.
REQ-017 SHALL have port stats_ndrop, output, STAT_W: duplicate requests discarded.
REQ-018 SHALL have port occupancy, output, log2(DEPTH)+1: current entry count.

Function
REQ-019 SHALL complete a transfer on either port exactly when valid=1 and retry=0 in the same cycle.
REQ-020 SHALL drive pftodc_req_retry = 1 iff occupancy == DEPTH at cycle start; no dependence on dcreq_retry (no combinational path retry-to-retry).
REQ-021 SHALL treat an accepted request as duplicate iff some entry valid at cycle start (including head being popped that cycle) matches sptbr and laddr[LADDR_W-1:LINE_BITS]; l2 bit ignored in compare.
REQ-022 SHALL discard a duplicate (no write, occupancy unchanged by it) and increment stats_ndrop.
REQ-023 SHALL, for a duplicate with req_l2=0 matching an entry with l2=1, clear that entry's l2 bit (upgrade to DC fill); no other field changes.
REQ-024 SHALL write a non-duplicate accepted request at the tail and increment stats_nreqs.
REQ-025 SHALL drive dcreq_valid = (occupancy != 0) and dcreq_* from the head entry, registered, no input-to-output combinational path.
REQ-026 SHALL pop the head on a DC-side transfer; zero-latency bypass not allowed: a request enqueued in cycle N appears on dcreq no earlier than N+1.
REQ-027 SHALL hold dcreq_* stable while dcreq_valid=1 and dcreq_retry=1, except the l2 upgrade of REQ-023 on the head.
REQ-028 SHALL support simultaneous push and pop in one cycle; occupancy unchanged, order preserved.
REQ-029 SHALL wrap head/tail pointers modulo DEPTH.
REQ-030 SHALL saturate stats counters at 2^STAT_W-1, never wrap.
REQ-031 SHALL deliver entries to DC strictly in enqueue order.

Reset
REQ-032 SHALL, while reset=0, asynchronously force occupancy=0, pointers=0, dcreq_valid=0, pftodc_req_retry=0, stats=0; entry data unspecified.
REQ-033 SHALL drop all buffered entries on reset mid-operation; no transfer occurs in a cycle where reset=0.
REQ-034 SHALL resume accepting on the first rising edge after reset returns to 1.

Verification
REQ-035 SHALL verify: four distinct laddr 0x1000,0x2000,0x3000,0x4000 pushed with dcreq_retry=1 -> occupancy=4, pftodc_req_retry=1, fifth push not taken, stats_nreqs=4.
REQ-036 SHALL verify: push 0x1000 then 0x1020 same sptbr -> second dropped, occupancy=1, stats_ndrop=1; 0x1040 with different sptbr -> enqueued.
REQ-037 SHALL verify: full buffer, dcreq_retry=0 for one cycle -> head 0x1000 popped, retry=0 next cycle, push 0x5000 lands at tail, output order 0x2000,0x3000,0x4000,0x5000.
REQ-038 SHALL verify: head 0x1000 l2=1 held by dcreq_retry=1, push 0x1008 l2=0 -> ndrop+1, dcreq_l2 becomes 0, laddr unchanged.
REQ-039 SHALL verify: reset=0 asserted with occupancy=3 -> dcreq_valid=0 and occupancy=0 immediately without clock edge, stats=0.
REQ-040 SHALL verify: 2^STAT_W+5 duplicate pushes -> stats_ndrop holds 2^STAT_W-1.
